// File: rtl/dma_32b_16b_if.sv
// Bus bundle for the frame-buffer read-side unpacker: read FIFO side plus
// pixel side. The DUT connects through the slave modport, and the driver
// of the FIFO/video timing connects through the master modport.
interface dma_32b_16b_if;
  logic        dma_rst_i;
  logic        dma_de_16b_i;
  logic        dma_empty_i;
  logic        dma_rd_32b_o;
  logic [31:0] dma_d_32b_i;
  logic        dma_de_16b_o;
  logic [15:0] dma_d_16b_o;
  logic        dma_underflow_o;

  modport master (
    output dma_rst_i, dma_de_16b_i, dma_empty_i, dma_d_32b_i,
    input  dma_rd_32b_o, dma_de_16b_o, dma_d_16b_o, dma_underflow_o
  );

  modport slave (
    input  dma_rst_i, dma_de_16b_i, dma_empty_i, dma_d_32b_i,
    output dma_rd_32b_o, dma_de_16b_o, dma_d_16b_o, dma_underflow_o
  );
endinterface

// File: rtl/dma_32b_16b.sv
// Frame-buffer read-side unpacker. It prefetches 32-bit words from the DDR
// read FIFO into a 2-entry buffer and emits one 16-bit pixel per requested
// cycle, low halfword first. Each line starts word-aligned, so a line that
// ended on a low halfword has its half-used word dropped at the next line start.
module dma_32b_16b #(
  parameter logic [15:0] FILL_PIX = 16'h0000
) (
  input  logic          sys_clk,
  input  logic          rst,
  dma_32b_16b_if.slave  bus
);

  logic [31:0] buf0_q, buf0_d;
  logic [31:0] buf1_q, buf1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        half_q, half_d;
  logic        de_q, de_d;
  logic        de_o_q, de_o_d;
  logic [15:0] pix_q, pix_d;
  logic        uf_q, uf_d;
  logic        rd;

  // The read strobe counts the word still in flight as well, so the buffer
  // can never be overrun.
  assign rd = !rst && !bus.dma_rst_i && !bus.dma_empty_i &&
              (({1'b0, cnt_q} + {2'b00, pend_q}) < 3'd2);

  assign bus.dma_rd_32b_o    = rd;
  assign bus.dma_de_16b_o    = de_o_q;
  assign bus.dma_d_16b_o     = pix_q;
  assign bus.dma_underflow_o = uf_q;

  // Next state: push the arriving word, then line-start realign, then consume.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;
    half_d = half_q;
    pend_d = rd;
    de_d   = bus.dma_de_16b_i;
    de_o_d = 1'b0;
    pix_d  = pix_q;
    uf_d   = uf_q;

    // A word can only be in flight while cnt <= 1, so it always fits in the buffer.
    if (pend_q) begin
      if (cnt_d == 2'd0) begin
        buf0_d = bus.dma_d_32b_i;
      end else begin
        buf1_d = bus.dma_d_32b_i;
      end
      cnt_d = cnt_d + 2'd1;
    end

    if (bus.dma_de_16b_i) begin
      de_o_d = 1'b1;
      // The previous line ended on a low halfword. Its head word is finished.
      if (!de_q && half_d) begin
        if (cnt_d != 2'd0) begin
          buf0_d = buf1_d;
          cnt_d  = cnt_d - 2'd1;
        end
        half_d = 1'b0;
      end
      if (cnt_d == 2'd0) begin
        pix_d = FILL_PIX;
        uf_d  = 1'b1;
      end else begin
        pix_d = half_d ? buf0_d[31:16] : buf0_d[15:0];
        if (half_d) begin
          buf0_d = buf1_d;
          cnt_d  = cnt_d - 2'd1;
        end
        half_d = !half_d;
      end
    end

    // A frame-start flush drops the buffer and any word in flight or arriving.
    if (bus.dma_rst_i) begin
      cnt_d  = 2'd0;
      half_d = 1'b0;
      pend_d = 1'b0;
      uf_d   = 1'b0;
      de_o_d = 1'b0;
      pix_d  = 16'h0000;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      buf0_q <= 32'h0;
      buf1_q <= 32'h0;
      cnt_q  <= 2'd0;
      pend_q <= 1'b0;
      half_q <= 1'b0;
      de_q   <= 1'b0;
      de_o_q <= 1'b0;
      pix_q  <= 16'h0000;
      uf_q   <= 1'b0;
    end else begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      half_q <= half_d;
      de_q   <= de_d;
      de_o_q <= de_o_d;
      pix_q  <= pix_d;
      uf_q   <= uf_d;
    end
  end

endmodule

// File: tb/tb_dma_32b_16b.sv
// Bench for the 32b->16b read-side unpacker. A queue models the read FIFO,
// which returns data one cycle after each strobe. Expected pixels are pushed
// to a scoreboard when a request is driven and popped when dma_de_16b_o appears.
module tb_dma_32b_16b;

  logic sys_clk = 1'b0;
  logic rst = 1'b1;

  dma_32b_16b_if bus ();

  dma_32b_16b dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          rs;
    bit          fl;
    bit          de;
    bit          lv;
    logic [31:0] w;
    logic [15:0] pix;
    bit          uf;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] fifo_q[$];
  logic [15:0] sb_q[$];
  logic [31:0] next_d;
  bit          next_d_v = 1'b0;
  bit          armed = 1'b0;
  bit          prev_de = 1'b0;
  bit          prev_rst = 1'b0;
  bit          exp_uf = 1'b0;
  bit          force_empty = 1'b0;
  bit          last_rd = 1'b0;
  int          rd_cnt = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  function automatic void add(input bit rs, input bit fl, input bit de, input bit lv,
                              input logic [31:0] w, input logic [15:0] pix, input bit uf);
    vec_t v;
    v.rs = rs; v.fl = fl; v.de = de; v.lv = lv; v.w = w; v.pix = pix; v.uf = uf;
    vecs.push_back(v);
  endfunction

  // One clock cycle: check what the previous cycle produced, then drive this one.
  task automatic step(input bit rs, input bit fl, input bit de,
                      input logic [15:0] pix, input bit uf_after);
    @(negedge sys_clk);
    if (armed) begin
      chk("de_out", {31'b0, bus.dma_de_16b_o}, {31'b0, prev_de});
      if (bus.dma_de_16b_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL pixel_extra: got %h, required no pixel", bus.dma_d_16b_o);
        end else begin
          chk("pixel", {16'h0, bus.dma_d_16b_o}, {16'h0, sb_q.pop_front()});
        end
      end
      chk("underflow", {31'b0, bus.dma_underflow_o}, {31'b0, exp_uf});
      if (prev_rst) chk("pix_after_rst", {16'h0, bus.dma_d_16b_o}, 32'h0);
    end
    armed = 1'b1;
    bus.dma_d_32b_i  = next_d_v ? next_d : 32'hDEAD_BEEF;
    next_d_v         = 1'b0;
    rst              = rs;
    bus.dma_rst_i    = fl;
    bus.dma_de_16b_i = de;
    bus.dma_empty_i  = force_empty || (fifo_q.size() == 0);
    if (de && !fl && !rs) sb_q.push_back(pix);
    prev_de  = de && !fl && !rs;
    prev_rst = rs;
    exp_uf   = uf_after;
    #1;
    last_rd = bus.dma_rd_32b_o;
    if (rs || fl) chk("no_rd_in_reset", {31'b0, last_rd}, 32'h0);
    if (last_rd) begin
      chk("rd_when_empty", {31'b0, bus.dma_empty_i}, 32'h0);
      rd_cnt++;
      if (fifo_q.size() > 0) begin
        next_d   = fifo_q.pop_front();
        next_d_v = 1'b1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.dma_rst_i    = 1'b0;
    bus.dma_de_16b_i = 1'b0;
    bus.dma_empty_i  = 1'b1;
    bus.dma_d_32b_i  = 32'h0;

    // Reset, then the contiguous line.
    add(1, 0, 0, 0, 32'h0, 16'h0, 0);
    add(1, 0, 0, 0, 32'h0, 16'h0, 0);
    add(0, 1, 0, 1, 32'h0002_0001, 16'h0, 0);
    add(0, 0, 0, 1, 32'h0004_0003, 16'h0, 0);
    add(0, 0, 0, 1, 32'h0006_0005, 16'h0, 0);
    add(0, 0, 0, 0, 32'h0, 16'h0, 0);
    add(0, 0, 0, 0, 32'h0, 16'h0, 0);
    for (int i = 1; i <= 6; i++) add(0, 0, 1, 0, 32'h0, 16'(i), 0);
    add(0, 0, 0, 0, 32'h0, 16'h0, 0);
    // Odd line width: the second line skips halfword 4.
    add(0, 1, 0, 1, 32'h0002_0001, 16'h0, 0);
    add(0, 0, 0, 1, 32'h0004_0003, 16'h0, 0);
    add(0, 0, 0, 1, 32'h0006_0005, 16'h0, 0);
    add(0, 0, 0, 1, 32'h0008_0007, 16'h0, 0);
    add(0, 0, 0, 0, 32'h0, 16'h0, 0);
    add(0, 0, 1, 0, 32'h0, 16'h0001, 0);
    add(0, 0, 1, 0, 32'h0, 16'h0002, 0);
    add(0, 0, 1, 0, 32'h0, 16'h0003, 0);
    add(0, 0, 0, 0, 32'h0, 16'h0, 0);
    add(0, 0, 0, 0, 32'h0, 16'h0, 0);
    add(0, 0, 1, 0, 32'h0, 16'h0005, 0);
    add(0, 0, 1, 0, 32'h0, 16'h0006, 0);
    add(0, 0, 0, 0, 32'h0, 16'h0, 0);
    // Underflow with an empty FIFO, then recovery once a word shows up.
    add(0, 1, 0, 0, 32'h0, 16'h0, 0);
    add(0, 0, 0, 0, 32'h0, 16'h0, 0);
    add(0, 0, 0, 0, 32'h0, 16'h0, 0);
    add(0, 0, 0, 0, 32'h0, 16'h0, 0);
    add(0, 0, 1, 0, 32'h0, 16'h0000, 1);
    add(0, 0, 1, 0, 32'h0, 16'h0000, 1);
    add(0, 0, 0, 0, 32'h0, 16'h0, 1);
    add(0, 0, 0, 0, 32'h0, 16'h0, 1);
    add(0, 0, 0, 1, 32'h0008_0007, 16'h0, 1);
    add(0, 0, 0, 0, 32'h0, 16'h0, 1);
    add(0, 0, 0, 0, 32'h0, 16'h0, 1);
    add(0, 0, 0, 0, 32'h0, 16'h0, 1);
    add(0, 0, 1, 0, 32'h0, 16'h0007, 1);
    add(0, 0, 1, 0, 32'h0, 16'h0008, 1);
    add(0, 0, 0, 0, 32'h0, 16'h0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rs || vecs[i].fl) begin
        fifo_q.delete();
        rd_cnt = 0;
      end
      if (vecs[i].lv) fifo_q.push_back(vecs[i].w);
      step(vecs[i].rs, vecs[i].fl, vecs[i].de, vecs[i].pix, vecs[i].uf);
    end

    // Flush mid-line with a read in flight. The flag is set again first so
    // that the flush has something to clear.
    fifo_q.delete();
    step(0, 1, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 0);
    step(0, 0, 1, 16'h0000, 1);
    fifo_q.push_back(32'h0002_0001);
    fifo_q.push_back(32'h0004_0003);
    fifo_q.push_back(32'h0006_0005);
    repeat (4) step(0, 0, 0, 16'h0, 1);
    step(0, 0, 1, 16'h0001, 1);
    step(0, 0, 1, 16'h0002, 1);
    step(0, 0, 1, 16'h0003, 1);
    chk("strobe_before_flush", {31'b0, last_rd}, 32'h1);
    fifo_q.delete();
    step(0, 1, 1, 16'h0, 0);
    step(0, 0, 0, 16'h0, 0);
    // With the in-flight word dropped the buffer is empty, so this request underflows.
    step(0, 0, 1, 16'h0000, 1);
    step(0, 0, 0, 16'h0, 1);
    fifo_q.push_back(32'h0D02_0D01);
    fifo_q.push_back(32'h0D04_0D03);
    step(0, 1, 0, 16'h0, 0);
    repeat (4) step(0, 0, 0, 16'h0, 0);
    step(0, 0, 1, 16'h0D01, 0);
    step(0, 0, 1, 16'h0D02, 0);
    step(0, 0, 0, 16'h0, 0);

    // Back-pressure: FIFO reports empty every other cycle during a 16-pixel line.
    fifo_q.delete();
    for (int k = 0; k < 9; k++) fifo_q.push_back({16'(2 * k + 2), 16'(2 * k + 1)});
    step(0, 1, 0, 16'h0, 0);
    rd_cnt = 0;
    repeat (4) step(0, 0, 0, 16'h0, 0);
    for (int i = 0; i < 16; i++) begin
      force_empty = i[0];
      step(0, 0, 1, 16'(i + 1), 0);
      chk("outstanding_le2", {31'b0, (rd_cnt - i / 2) <= 2}, 32'h1);
    end
    force_empty = 1'b0;
    step(0, 0, 0, 16'h0, 0);

    // Reset mid-line, then a cold fill identical to the one after a flush.
    fifo_q.delete();
    fifo_q.push_back(32'h0002_0001);
    fifo_q.push_back(32'h0004_0003);
    fifo_q.push_back(32'h0006_0005);
    step(0, 1, 0, 16'h0, 0);
    repeat (4) step(0, 0, 0, 16'h0, 0);
    step(0, 0, 1, 16'h0001, 0);
    step(0, 0, 1, 16'h0002, 0);
    step(0, 0, 1, 16'h0003, 0);
    fifo_q.delete();
    fifo_q.push_back(32'h2222_2221);
    fifo_q.push_back(32'h2224_2223);
    fifo_q.push_back(32'h2226_2225);
    step(1, 0, 1, 16'h0, 0);
    step(0, 0, 0, 16'h0, 0);
    chk("cold_rd_first", {31'b0, last_rd}, 32'h1);
    step(0, 0, 0, 16'h0, 0);
    chk("cold_rd_second", {31'b0, last_rd}, 32'h1);
    step(0, 0, 0, 16'h0, 0);
    chk("cold_rd_full", {31'b0, last_rd}, 32'h0);
    step(0, 0, 1, 16'h2221, 0);
    step(0, 0, 1, 16'h2222, 0);
    step(0, 0, 1, 16'h2223, 0);
    step(0, 0, 1, 16'h2224, 0);
    step(0, 0, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 0);

    chk("scoreboard_drained", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
